colormem_multi: RTL and testbench



---
 rtl/xosera_pkg.sv | 17 +
 rtl/colormem_bank.sv | 22 ++
 rtl/colormem_multi.sv | 138 +++++++++++++
 tb/tb_colormem_multi.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xosera_pkg.sv
// Shared types for the colour memory: the video word and the controller states.
package xosera_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ACK
  } colormem_state_t;

  // Width of a bank-select field; a single bank still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/colormem_bank.sv
// One colour bank: 1R1W synchronous block RAM, registered read, contents not reset.
module colormem_bank #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/colormem_multi.sv
// Multi-bank colour lookup: per-bank video read channels plus an arbitrated shared
// host port with read-during-write bypass and a power-on ramp loader.
module colormem_multi
  import xosera_pkg::*;
#(
  parameter int   AWIDTH        = 8,
  parameter int   DWIDTH        = $bits(word_t),
  parameter int   NCHAN         = 2,
  parameter int   MAX_WAIT      = 15,
  parameter bit   INIT_ON_RESET = 1'b1,
  localparam int  CW            = sel_width(NCHAN)
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic [NCHAN-1:0]        vid_rd_en_i,
  input  logic [NCHAN*AWIDTH-1:0] vid_rd_addr_i,
  output logic [NCHAN*DWIDTH-1:0] vid_rd_data_o,
  output logic [NCHAN-1:0]        vid_rd_valid_o,
  input  logic                    host_req_i,
  input  logic                    host_wr_i,
  input  logic [CW-1:0]           host_chan_i,
  input  logic [AWIDTH-1:0]       host_addr_i,
  input  logic [DWIDTH-1:0]       host_data_i,
  output logic                    host_ack_o,
  output logic [DWIDTH-1:0]       host_data_o,
  output logic                    init_busy_o
);

  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  colormem_state_t   state, state_next;
  logic [AWIDTH-1:0] init_cnt;
  logic [WW-1:0]     wait_cnt;

  logic [NCHAN-1:0]  host_sel, bank_we, bank_re, vid_go, vid_valid_q, byp_q, byp_hit;
  logic              is_init, rd_want, vid_conflict, preempt, rd_blocked, wr_acc, rd_acc;
  logic [AWIDTH-1:0] bank_waddr;
  logic [DWIDTH-1:0] bank_wdata, byp_data_q, host_hold_q, host_word;
  logic [AWIDTH-1:0] bank_raddr [NCHAN];
  logic [DWIDTH-1:0] bank_q     [NCHAN];
  logic [DWIDTH-1:0] vid_word   [NCHAN];
  logic [DWIDTH-1:0] vid_hold_q [NCHAN];
  logic              host_rd_q;
  logic [CW-1:0]     host_chan_q;

  // Request decode and arbitration; an out-of-range bank selects nothing.
  always_comb begin
    host_sel = '0;
    for (int unsigned c = 0; c < NCHAN; c++) host_sel[c] = (host_chan_i == CW'(c));
    is_init      = (state == INIT);
    wr_acc       = (state == IDLE) && host_req_i && host_wr_i;
    rd_want      = (state == IDLE) && host_req_i && !host_wr_i;
    vid_conflict = |(host_sel & vid_rd_en_i);
    preempt      = rd_want && vid_conflict && (wait_cnt == WW'(MAX_WAIT));
    rd_blocked   = rd_want && vid_conflict && !preempt;
    rd_acc       = rd_want && !rd_blocked;
  end

  // Bank port muxing: init ramp vs host on the write side, video vs host on the read side.
  always_comb begin
    bank_waddr = is_init ? init_cnt : host_addr_i;
    bank_wdata = is_init ? DWIDTH'(init_cnt) : host_data_i;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      bank_we[c]    = is_init || (wr_acc && host_sel[c]);
      vid_go[c]     = vid_rd_en_i[c] && !is_init && !(preempt && host_sel[c]);
      bank_re[c]    = vid_go[c] || (rd_acc && host_sel[c]);
      bank_raddr[c] = (rd_acc && host_sel[c]) ? host_addr_i : vid_rd_addr_i[c*AWIDTH +: AWIDTH];
      byp_hit[c]    = wr_acc && host_sel[c] && vid_go[c] &&
                      (vid_rd_addr_i[c*AWIDTH +: AWIDTH] == host_addr_i);
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_bank
    colormem_bank #(
      .AWIDTH(AWIDTH),
      .DWIDTH(DWIDTH)
    ) u_bank (
      .clk    (clk),
      .wr_en  (bank_we[g]),
      .wr_addr(bank_waddr),
      .wr_data(bank_wdata),
      .rd_en  (bank_re[g]),
      .rd_addr(bank_raddr[g]),
      .rd_data(bank_q[g])
    );
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (init_cnt == '1) state_next = IDLE;
      IDLE:    if (wr_acc || rd_acc) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bank outputs are shared by video and host, so each side keeps its own hold copy.
  always_comb begin
    vid_rd_data_o = '0;
    host_word     = '0;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      vid_word[c] = vid_valid_q[c] ? (byp_q[c] ? byp_data_q : bank_q[c]) : vid_hold_q[c];
      vid_rd_data_o[c*DWIDTH +: DWIDTH] = vid_word[c];
      if (host_chan_q == CW'(c)) host_word = bank_q[c];
    end
    host_data_o    = host_rd_q ? host_word : host_hold_q;
    vid_rd_valid_o = vid_valid_q;
    host_ack_o     = (state == ACK);
    init_busy_o    = is_init;
  end

  always_ff @(posedge clk) begin
    byp_data_q <= host_data_i;
    if (!reset_n_i) begin
      state       <= INIT_ON_RESET ? INIT : IDLE;
      init_cnt    <= '0;
      wait_cnt    <= '0;
      vid_valid_q <= '0;
      byp_q       <= '0;
      host_rd_q   <= 1'b0;
      host_chan_q <= '0;
      host_hold_q <= '0;
      for (int unsigned c = 0; c < NCHAN; c++) vid_hold_q[c] <= '0;
    end else begin
      state       <= state_next;
      init_cnt    <= is_init ? init_cnt + 1'b1 : '0;
      wait_cnt    <= rd_blocked ? wait_cnt + 1'b1 : '0;
      vid_valid_q <= vid_go;
      byp_q       <= byp_hit;
      host_rd_q   <= rd_acc;
      host_chan_q <= host_chan_i;
      host_hold_q <= host_data_o;
      for (int unsigned c = 0; c < NCHAN; c++) vid_hold_q[c] <= vid_word[c];
    end
  end

endmodule

// File: tb/tb_colormem_multi.sv
// Directed bench for colormem_multi with a transaction-level reference model checked every cycle.
module tb_colormem_multi;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NC = 3;
  localparam int MW = 15;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [NC-1:0]     vid_en;
  logic [NC*AW-1:0]  vid_addr;
  logic [NC*DW-1:0]  vid_data;
  logic [NC-1:0]     vid_valid;
  logic              req, wr;
  logic [CW-1:0]     chan;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic              ack;
  logic [DW-1:0]     hdata;
  logic              busy;

  int errors = 0;
  int checks = 0;

  colormem_multi #(
    .AWIDTH(AW),
    .DWIDTH(DW),
    .NCHAN(NC),
    .MAX_WAIT(MW),
    .INIT_ON_RESET(1'b1)
  ) dut (
    .clk           (clk),
    .reset_n_i     (reset_n),
    .vid_rd_en_i   (vid_en),
    .vid_rd_addr_i (vid_addr),
    .vid_rd_data_o (vid_data),
    .vid_rd_valid_o(vid_valid),
    .host_req_i    (req),
    .host_wr_i     (wr),
    .host_chan_i   (chan),
    .host_addr_i   (addr),
    .host_data_i   (wdata),
    .host_ack_o    (ack),
    .host_data_o   (hdata),
    .init_busy_o   (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bank contents as arrays, one transaction decision per clock.
  logic [DW-1:0] m_mem [NC][256];
  int            init_left;
  bit            in_ack;
  int            blocked;
  bit            model_ok = 1'b0;
  logic [NC-1:0] e_valid;
  logic [DW-1:0] e_vdata [NC];
  bit            e_ack, e_busy;
  logic [DW-1:0] e_hdata;

  always @(posedge clk) begin : model
    int take;
    bit acc, busy_now;
    if (!reset_n) begin
      init_left = 256; in_ack = 0; blocked = 0; model_ok = 1'b1;
      e_valid = '0; e_ack = 0; e_busy = 1; e_hdata = '0;
      for (int c = 0; c < NC; c++) e_vdata[c] = '0;
    end else begin
      take = -1; acc = 0;
      busy_now = (init_left > 0);
      if (busy_now) begin
        for (int c = 0; c < NC; c++) m_mem[c][256-init_left] = DW'(256 - init_left);
        init_left--;
      end else if (!in_ack && req) begin
        if (wr) begin
          acc = 1;
          if (int'(chan) < NC) m_mem[chan][addr] = wdata;
        end else if (int'(chan) >= NC || !vid_en[chan] || blocked == MW) begin
          acc = 1;
          e_hdata = (int'(chan) < NC) ? m_mem[chan][addr] : '0;
          if (int'(chan) < NC && vid_en[chan]) take = int'(chan);
        end else begin
          blocked++;
        end
      end
      if (acc) blocked = 0;
      for (int c = 0; c < NC; c++) begin
        if (!busy_now && vid_en[c] && c != take) begin
          e_valid[c] = 1'b1;
          e_vdata[c] = m_mem[c][vid_addr[c*AW +: AW]];
        end else begin
          e_valid[c] = 1'b0;
        end
      end
      e_ack  = acc;
      in_ack = acc;
      e_busy = (init_left > 0);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int c = 0; c < NC; c++) begin
        check($sformatf("vid_valid%0d", c), vid_valid[c], e_valid[c]);
        check($sformatf("vid_data%0d", c), vid_data[c*DW +: DW], e_vdata[c]);
      end
      check("host_ack", ack, e_ack);
      check("host_data", hdata, e_hdata);
      check("init_busy", busy, e_busy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vaddr(input int c, input logic [AW-1:0] a);
    vid_addr[c*AW +: AW] = a;
  endtask

  // Steps until init_busy_o falls; returns edges taken and acks seen on the way.
  task automatic count_init(output int n, output int acks);
    n = 0; acks = 0;
    do begin
      step();
      n++;
      if (ack) acks++;
    end while (busy && n < 1000);
  endtask

  initial begin
    int n, acks, gaps0, gaps1, ackcyc;
    reset_n = 0; vid_en = '0; vid_addr = '0; req = 0; wr = 0; chan = '0; addr = '0; wdata = '0;
    step(); step();
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 1);
    check("rst_valid", vid_valid, 0);
    check("rst_vdata", vid_data, 0);
    check("rst_hdata", hdata, 0);
    reset_n = 1;
    count_init(n, acks);
    check("init_cycles", n, 256);

    // Ramp contents on ch1.
    vid_en = 3'b010; set_vaddr(1, 8'h2A);
    check("ramp_pre_valid", vid_valid[1], 0);
    step();
    vid_en = '0;
    check("ramp_valid", vid_valid[1], 1);
    check("ramp_data", vid_data[1*DW +: DW], 16'h002A);

    // Host write ch0 then read both banks at the same address.
    req = 1; wr = 1; chan = 0; addr = 8'h10; wdata = 16'hF0F0;
    step();
    req = 0;
    check("wr_ack", ack, 1);
    step();
    check("wr_ack_once", ack, 0);
    vid_en = 3'b011; set_vaddr(0, 8'h10); set_vaddr(1, 8'h10);
    step();
    vid_en = '0;
    check("wr_ch0", vid_data[0*DW +: DW], 16'hF0F0);
    check("wr_ch1_untouched", vid_data[1*DW +: DW], 16'h0010);

    // Same-cycle write and video read on ch1 addr 5.
    req = 1; wr = 1; chan = 1; addr = 8'h05; wdata = 16'h1234;
    vid_en = 3'b010; set_vaddr(1, 8'h05);
    step();
    req = 0; vid_en = '0;
    check("byp_valid", vid_valid[1], 1);
    check("byp_data", vid_data[1*DW +: DW], 16'h1234);
    check("byp_ack", ack, 1);
    step();

    // Host read of ch0 starved by continuous video on ch0; ch1 also streaming.
    vid_en = 3'b011; set_vaddr(0, 8'h20); set_vaddr(1, 8'h33);
    req = 1; wr = 0; chan = 0; addr = 8'h10;
    gaps0 = 0; gaps1 = 0; ackcyc = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (!vid_valid[0]) begin
        gaps0++;
        check("gap_hold", vid_data[0*DW +: DW], 16'h0020);
      end
      if (!vid_valid[1]) gaps1++;
      if (ack && ackcyc == 0) begin
        ackcyc = i;
        req = 0;
        check("starve_hdata", hdata, 16'hF0F0);
      end
    end
    vid_en = '0;
    check("starve_acked", (ackcyc > 0 && ackcyc <= 17), 1);
    check("starve_gaps0", gaps0, 1);
    check("starve_gaps1", gaps1, 0);
    step();

    // Out-of-range bank: write discarded, read returns zero.
    req = 1; wr = 1; chan = 3; addr = 8'h10; wdata = 16'hBEEF;
    step();
    req = 0;
    check("oob_wr_ack", ack, 1);
    step();
    vid_en = 3'b111; set_vaddr(0, 8'h10); set_vaddr(1, 8'h10); set_vaddr(2, 8'h10);
    step();
    vid_en = '0;
    check("oob_ch0", vid_data[0*DW +: DW], 16'hF0F0);
    check("oob_ch1", vid_data[1*DW +: DW], 16'h0010);
    check("oob_ch2", vid_data[2*DW +: DW], 16'h0010);
    req = 1; wr = 0; chan = 3; addr = 8'h10;
    step();
    req = 0;
    check("oob_rd_ack", ack, 1);
    check("oob_rd_data", hdata, 16'h0000);
    step();

    // Reset pulse at init count 100 restarts the ramp; pending host write ignored.
    reset_n = 0;
    step();
    reset_n = 1;
    for (int i = 0; i < 100; i++) step();
    check("mid_busy", busy, 1);
    reset_n = 0; req = 1; wr = 1; chan = 0; addr = 8'h44; wdata = 16'hAAAA;
    step();
    reset_n = 1;
    count_init(n, acks);
    req = 0;
    check("restart_cycles", n, 256);
    check("restart_no_ack", acks, 0);
    vid_en = 3'b001; set_vaddr(0, 8'h10);
    step();
    vid_en = '0;
    check("restart_reramp", vid_data[0*DW +: DW], 16'h0010);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
